viterbi_decoder_k: RTL and testbench

Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes with constraint length K and generator polynomials G0/G1 set at elaboration.
- Sits downstream of the channel/demod path; accepts one 2-bit encoded symbol per handshake and emits one decoded bit per symbol once the traceback window has filled.
- Successor to the fixed K=3, 15-column trellis decoder: arbitrary K, parallel ACS over all states, metric normalisation, ring survivor memory, traceback FSM and valid/ready flow control.

---
 rtl/viterbi_pkg.sv | 24 ++
 rtl/viterbi_decoder_k_acs.sv | 20 ++
 rtl/viterbi_decoder_k.sv | 159 +++++++++++++++
 tb/tb_viterbi_decoder_k.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the hard-decision Viterbi decoder.
`default_nettype none

package viterbi_pkg;

  localparam int K_MAX = 7;

  typedef enum logic [1:0] {
    ACS   = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } fsm_t;

  function automatic logic parity(input logic [K_MAX-1:0] vec);
    return ^vec;
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic c0, input logic c1);
    return 2'(rx[1] ^ c0) + 2'(rx[0] ^ c1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_decoder_k_acs.sv
// Compare-select for one trellis state: keeps the smaller candidate, ties favour predecessor 0.
`default_nettype none

module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] cand0,
  input  logic [PM_W-1:0] cand1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  assign dec    = (cand1 < cand0);
  assign pm_new = dec ? cand1 : cand0;

endmodule

`default_nettype wire

// File: rtl/viterbi_decoder_k.sv
// Rate-1/2 hard-decision Viterbi decoder: parallel ACS, ring survivor memory, traceback FSM.
// Optional macro VIT_BEST_PM_EN adds the best_pm output.
`default_nettype none

module viterbi_decoder_k
  import viterbi_pkg::*;
#(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             PM_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_bits,
  output logic            out_valid,
  output logic            out_bit
`ifdef VIT_BEST_PM_EN
  ,
  output logic [PM_W-1:0] best_pm
`endif
);

  localparam int NS    = 1 << (K - 1);
  localparam int HALF  = NS / 2;
  localparam int SW    = K - 1;
  localparam int PTR_W = $clog2(TB_DEPTH);
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  fsm_t             state, state_nxt;
  logic [PM_W-1:0]  pm     [NS];
  logic [PM_W-1:0]  pm_new [NS];
  logic [NS-1:0]    dec_vec;
  logic [NS-1:0]    mem    [TB_DEPTH];
  logic [NS-1:0]    col_dec;
  logic [PTR_W-1:0] wr_ptr, tb_col;
  logic [CNT_W-1:0] fill, fill_inc, tb_cnt;
  logic [SW-1:0]    tb_state, tb_prev, min_idx;
  logic [PM_W-1:0]  min_pm;
  logic             accept, all_msb, trace_last;

  // Each state s is reached with input bit s[MSB] from {s[K-3:0],0} and {s[K-3:0],1}.
  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam int P0 = (s % HALF) * 2;
    localparam int B  = s / HALF;
    localparam logic [K-1:0] R0 = K'(B * NS + P0);
    localparam logic [K-1:0] R1 = K'(B * NS + P0 + 1);
    logic [1:0]      bm0, bm1;
    logic [PM_W-1:0] cand0, cand1;

    assign bm0   = branch_metric(in_bits, parity(K_MAX'(R0 & G0)), parity(K_MAX'(R0 & G1)));
    assign bm1   = branch_metric(in_bits, parity(K_MAX'(R1 & G0)), parity(K_MAX'(R1 & G1)));
    assign cand0 = pm[P0] + PM_W'(bm0);
    assign cand1 = pm[P0 + 1] + PM_W'(bm1);

    viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
      .cand0  (cand0),
      .cand1  (cand1),
      .pm_new (pm_new[s]),
      .dec    (dec_vec[s])
    );
  end

  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS; i++) all_msb = all_msb & pm_new[i][PM_W-1];
  end

  always_comb begin
    min_pm  = pm[0];
    min_idx = '0;
    for (int i = 1; i < NS; i++) begin
      if (pm[i] < min_pm) begin
        min_pm  = pm[i];
        min_idx = SW'(i);
      end
    end
  end

  assign accept     = in_valid && in_ready;
  assign fill_inc   = (fill == CNT_W'(TB_DEPTH)) ? fill : fill + CNT_W'(1);
  assign trace_last = (state == TRACE) && (tb_cnt == CNT_W'(TB_DEPTH - 1));
  assign col_dec    = mem[tb_col];
  assign tb_prev    = {tb_state[K-3:0], col_dec[tb_state]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACS;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACS: begin
        in_ready = 1'b1;
        if (in_valid && (fill_inc == CNT_W'(TB_DEPTH))) state_nxt = TRACE;
      end
      TRACE: if (tb_cnt == CNT_W'(TB_DEPTH - 1)) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        state_nxt = ACS;
      end
      default: state_nxt = ACS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= dec_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
      wr_ptr   <= '0;
      fill     <= '0;
      tb_col   <= '0;
      tb_cnt   <= '0;
      tb_state <= '0;
      out_bit  <= 1'b0;
`ifdef VIT_BEST_PM_EN
      best_pm  <= '0;
`endif
    end else begin
      if (accept) begin
        // Clearing a common MSB is a uniform shift, so survivor choices are unaffected.
        for (int i = 0; i < NS; i++)
          pm[i] <= all_msb ? {1'b0, pm_new[i][PM_W-2:0]} : pm_new[i];
        wr_ptr <= (wr_ptr == PTR_W'(TB_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        fill   <= fill_inc;
        tb_col <= wr_ptr;
        tb_cnt <= '0;
      end
      if (state == TRACE) begin
        tb_cnt <= tb_cnt + CNT_W'(1);
        if (tb_cnt == '0) begin
          tb_state <= min_idx;
        end else begin
          tb_state <= tb_prev;
          tb_col   <= (tb_col == '0) ? PTR_W'(TB_DEPTH - 1) : tb_col - PTR_W'(1);
        end
        if (trace_last) begin
          out_bit <= tb_prev[K-2];
`ifdef VIT_BEST_PM_EN
          best_pm <= min_pm;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_viterbi_decoder_k.sv
// Directed and randomized checks of viterbi_decoder_k (K=3 default and a K=5 instance).
`default_nettype none

module tb_viterbi_decoder_k;

  localparam int TB3   = 15;
  localparam int K5    = 5;
  localparam int TB5   = 25;
  localparam int NS5   = 16;
  localparam int H5    = 8;
  localparam int NSYM5 = 400;
  localparam logic [4:0] G0_5 = 5'b10011;
  localparam logic [4:0] G1_5 = 5'b11101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v3, r3, ov3, ob3, v5, r5, ov5, ob5;
  logic [1:0] b3, b5;
`ifdef VIT_BEST_PM_EN
  logic [5:0] bp3, bp5;
`endif

  viterbi_decoder_k dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_bits(b3),
    .out_valid(ov3), .out_bit(ob3)
`ifdef VIT_BEST_PM_EN
    , .best_pm(bp3)
`endif
  );

  viterbi_decoder_k #(.K(5), .G0(5'b10011), .G1(5'b11101), .TB_DEPTH(25), .PM_W(6)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in_bits(b5),
    .out_valid(ov5), .out_bit(ob5)
`ifdef VIT_BEST_PM_EN
    , .best_pm(bp5)
`endif
  );

  logic       oq3 [$];
  int         ocyc3 [$];
  int         acyc3 [$];
  logic [5:0] bpq3 [$];
  logic       oq5 [$];

  always @(negedge clk) begin
    if (ov3) begin
      oq3.push_back(ob3);
      ocyc3.push_back(cyc);
`ifdef VIT_BEST_PM_EN
      bpq3.push_back(bp3);
`endif
    end
    if (!rst && v3 && r3) acyc3.push_back(cyc);
    if (ov5) oq5.push_back(ob5);
  end

  logic [5:0] msg3 = 6'b101100;
  logic [1:0] enc3 [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [1:0] rx5 [NSYM5];
  bit         decm [NSYM5][NS5];
  logic       exp5 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc_sym(input int k, input logic [31:0] g0, input logic [31:0] g1,
                                         input int b, input int p);
    logic [31:0] r;
    r = 32'((b << (k - 1)) | p);
    return {^(r & g0), ^(r & g1)};
  endfunction

  task automatic send(input bit sel5, input logic [1:0] b);
    int n;
    n = 0;
    if (sel5) begin v5 = 1'b1; b5 = b; end
    else      begin v3 = 1'b1; b3 = b; end
    @(negedge clk);
    while (!(sel5 ? r5 : r3) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", 64'(n < 200), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    v3 = 1'b0; v5 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear3();
    oq3.delete(); ocyc3.delete(); acyc3.delete(); bpq3.delete();
  endtask

  task automatic run_stream(input int err_idx);
    logic [1:0] s;
    clear3();
    for (int i = 0; i < 20; i++) begin
      s = (i < 6) ? enc3[i] : 2'b00;
      if (i == err_idx) s = s ^ 2'b01;
      send(1'b0, s);
      v3 = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (TB3 + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input int exp_bp);
    chk({tag, "_count"}, oq3.size(), 6);
    for (int i = 0; i < oq3.size() && i < 6; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), oq3[i], msg3[5 - i]);
      if (i + TB3 - 1 < acyc3.size())
        chk($sformatf("%s_latency%0d", tag, i), ocyc3[i] - acyc3[i + TB3 - 1], TB3 + 1);
`ifdef VIT_BEST_PM_EN
      chk($sformatf("%s_best_pm%0d", tag, i), bpq3[i], exp_bp);
`endif
    end
    if (exp_bp < 0) $display("unused");
  endtask

  // Unbounded-integer Viterbi over the whole received sequence.
  task automatic model5();
    int pmm [NS5];
    int npm [NS5];
    int ca, cb, pa, best, st;
    exp5.delete();
    for (int s = 0; s < NS5; s++) pmm[s] = (s == 0) ? 0 : 16;
    for (int n = 0; n < NSYM5; n++) begin
      for (int s = 0; s < NS5; s++) begin
        pa = (s % H5) * 2;
        ca = pmm[pa]     + $countones(rx5[n] ^ enc_sym(K5, 32'(G0_5), 32'(G1_5), s / H5, pa));
        cb = pmm[pa + 1] + $countones(rx5[n] ^ enc_sym(K5, 32'(G0_5), 32'(G1_5), s / H5, pa + 1));
        decm[n][s] = (cb < ca);
        npm[s] = (cb < ca) ? cb : ca;
      end
      pmm = npm;
      if (n >= TB5 - 1) begin
        best = 0;
        for (int s = 1; s < NS5; s++) if (pmm[s] < pmm[best]) best = s;
        st = best;
        for (int j = 0; j < TB5 - 1; j++) st = (st % H5) * 2 + int'(decm[n - j][st]);
        exp5.push_back(st >= H5);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    v3 = 1'b0; v5 = 1'b0; b3 = '0; b5 = '0;

    @(negedge clk);
    chk("rst_in_ready", r3, 1);
    chk("rst_out_valid", ov3, 0);
    chk("rst_out_bit", ob3, 0);
    chk("rst_in_ready_k5", r5, 1);
    chk("rst_out_valid_k5", ov5, 0);
`ifdef VIT_BEST_PM_EN
    chk("rst_best_pm", bp3, 0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    run_stream(-1);
    check_run("clean", 0);

    do_reset();
    run_stream(2);
    check_run("one_err", 1);

    do_reset();
    clear3();
    for (int i = 0; i < 40; i++) send(1'b0, 2'b00);
    v3 = 1'b0;
    repeat (TB3 + 4) @(posedge clk);
    #1;
    chk("zeros_accepts", acyc3.size(), 40);
    for (int i = 0; i + 1 < acyc3.size(); i++)
      chk($sformatf("zeros_gap%0d", i), acyc3[i + 1] - acyc3[i], (i >= 14) ? TB3 + 2 : 1);
    chk("zeros_count", oq3.size(), 26);
    for (int i = 0; i < oq3.size(); i++) chk($sformatf("zeros_bit%0d", i), oq3[i], 0);

    do_reset();
    clear3();
    for (int i = 0; i < 15; i++) begin
      send(1'b0, (i < 6) ? enc3[i] : 2'b00);
      v3 = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midtrace_rst_in_ready", r3, 1);
    chk("midtrace_rst_out_valid", ov3, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", r3, 1);
    repeat (TB3 + 4) @(posedge clk);
    #1;
    chk("midtrace_no_output", oq3.size(), 0);
    run_stream(-1);
    check_run("post_rst", 0);

    do_reset();
    oq5.delete();
    st = 0;
    for (int n = 0; n < NSYM5; n++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      rx5[n] = enc_sym(K5, 32'(G0_5), 32'(G1_5), int'(m), st);
      st = (int'(m) << (K5 - 2)) | (st >> 1);
      if ($urandom_range(0, 7) == 0) rx5[n] = rx5[n] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
    end
    model5();
    for (int n = 0; n < NSYM5; n++) begin
      send(1'b1, rx5[n]);
      v5 = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (TB5 + 4) @(posedge clk);
    #1;
    chk("k5_count", oq5.size(), exp5.size());
    for (int i = 0; i < oq5.size() && i < exp5.size(); i++)
      chk($sformatf("k5_bit%0d", i), oq5[i], exp5[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
